// File: rtl/rv32i_store_checker.sv
// Store-stream checker: matches core stores against a runtime-loaded expectation
// buffer (bounded out-of-order window), with tohost fallback and an idle watchdog.
module rv32i_store_checker #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned WINDOW         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       exp_valid_i,
    output logic                       exp_ready_o,
    input  logic [ADDR_W-1:0]          exp_addr_i,
    input  logic [DATA_W-1:0]          exp_data_i,
    input  logic [DATA_W/8-1:0]        exp_strb_i,
    input  logic                       arm_i,
    input  logic                       st_valid_i,
    input  logic [ADDR_W-1:0]          st_addr_i,
    input  logic [DATA_W-1:0]          st_data_i,
    input  logic [DATA_W/8-1:0]        st_strb_i,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [2:0]                 fail_code_o,
    output logic [$clog2(DEPTH+1)-1:0] matched_count_o,
    output logic [$clog2(DEPTH)-1:0]   fail_index_o
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [ADDR_W-1:0] TOHOST_A = ADDR_W'(TOHOST_ADDR);

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_MISMATCH = 3'd1;
    localparam logic [2:0] FC_TOHOST   = 3'd3;
    localparam logic [2:0] FC_TIMEOUT  = 3'd4;

    typedef enum logic [1:0] {LOAD, CHECK, TOHOST, DONE} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    occ_q, occ_d, remaining_q, remaining_d, matched_q, matched_d;
    logic [DEPTH-1:0]    consumed_q, consumed_d;
    logic                done_q, done_d, pass_q, pass_d;
    logic [2:0]          fail_code_q, fail_code_d;
    logic [PTR_W-1:0]    fail_index_q, fail_index_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [ADDR_W-1:0]   addr_d [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];
    logic [STRB_W-1:0]   strb_q [DEPTH];
    logic [STRB_W-1:0]   strb_d [DEPTH];

    logic                st_fire;
    logic                push, pop;
    logic [PTR_W-1:0]    win_slot [WINDOW];
    logic                match_found, match_at_head;
    logic [PTR_W-1:0]    match_slot;

    // An X on st_valid_i must never count as a store.
    assign st_fire     = (st_valid_i === 1'b1);
    assign exp_ready_o = (state_q == LOAD) && (occ_q != CNT_W'(DEPTH));

    function automatic logic entry_hit(
        input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed, input logic [STRB_W-1:0] es,
        input logic [ADDR_W-1:0] sa, input logic [DATA_W-1:0] sd, input logic [STRB_W-1:0] ss
    );
        logic hit;
        hit = (ea === sa) && (es === ss);
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (es[b] && (ed[8*b +: 8] !== sd[8*b +: 8])) hit = 1'b0;
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < int'(WINDOW); i++) begin
            win_slot[i] = head_q + PTR_W'(i);
        end
    end

    // Scan downwards so the lowest-offset hit is the one that survives.
    always_comb begin
        match_found   = 1'b0;
        match_at_head = 1'b0;
        match_slot    = head_q;
        for (int i = int'(WINDOW) - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < occ_q) && !consumed_q[win_slot[i]] &&
                entry_hit(addr_q[win_slot[i]], data_q[win_slot[i]], strb_q[win_slot[i]],
                          st_addr_i, st_data_i, st_strb_i)) begin
                match_found   = 1'b1;
                match_at_head = (i == 0);
                match_slot    = win_slot[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        occ_d        = occ_q;
        remaining_d  = remaining_q;
        matched_d    = matched_q;
        consumed_d   = consumed_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_code_d  = fail_code_q;
        fail_index_d = fail_index_q;
        timer_d      = timer_q;
        addr_d       = addr_q;
        data_d       = data_q;
        strb_d       = strb_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (clear_i) begin
            state_d      = LOAD;
            head_d       = '0;
            tail_d       = '0;
            occ_d        = '0;
            remaining_d  = '0;
            matched_d    = '0;
            consumed_d   = '0;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            fail_code_d  = FC_NONE;
            fail_index_d = '0;
            timer_d      = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    push = exp_valid_i && exp_ready_o;
                    if (push) begin
                        addr_d[tail_q] = exp_addr_i;
                        data_d[tail_q] = exp_data_i;
                        strb_d[tail_q] = exp_strb_i;
                        tail_d         = tail_q + 1'b1;
                        occ_d          = occ_q + 1'b1;
                        remaining_d    = remaining_q + 1'b1;
                    end
                    if (arm_i) begin
                        timer_d = '0;
                        state_d = (occ_d != '0) ? CHECK : TOHOST;
                    end
                end
                CHECK: begin
                    // A head hit retires immediately; otherwise drain one consumed head per cycle.
                    pop = consumed_q[head_q] || (st_fire && match_found && match_at_head);
                    if (st_fire) begin
                        timer_d = '0;
                        if (match_found) begin
                            consumed_d[match_slot] = 1'b1;
                            matched_d   = matched_q + 1'b1;
                            remaining_d = remaining_q - 1'b1;
                            if (remaining_q == CNT_W'(1)) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                                pass_d  = 1'b1;
                            end
                        end else begin
                            state_d      = DONE;
                            done_d       = 1'b1;
                            fail_code_d  = FC_MISMATCH;
                            fail_index_d = head_q;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (timer_q == TMR_LAST) begin
                            state_d     = DONE;
                            done_d      = 1'b1;
                            fail_code_d = FC_TIMEOUT;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                    if (pop) begin
                        consumed_d[head_q] = 1'b0;
                        head_d             = head_q + 1'b1;
                        occ_d              = occ_q - 1'b1;
                    end
                end
                TOHOST: begin
                    if (st_fire) begin
                        timer_d = '0;
                        if (st_addr_i == TOHOST_A) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            if (st_data_i == DATA_W'(1)) pass_d = 1'b1;
                            else                         fail_code_d = FC_TOHOST;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (timer_q == TMR_LAST) begin
                            state_d     = DONE;
                            done_d      = 1'b1;
                            fail_code_d = FC_TIMEOUT;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= LOAD;
            head_q       <= '0;
            tail_q       <= '0;
            occ_q        <= '0;
            remaining_q  <= '0;
            matched_q    <= '0;
            consumed_q   <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_code_q  <= FC_NONE;
            fail_index_q <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            remaining_q  <= remaining_d;
            matched_q    <= matched_d;
            consumed_q   <= consumed_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_code_q  <= fail_code_d;
            fail_index_q <= fail_index_d;
            timer_q      <= timer_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        data_q <= data_d;
        strb_q <= strb_d;
    end

    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign fail_code_o     = fail_code_q;
    assign matched_count_o = matched_q;
    assign fail_index_o    = fail_index_q;

    arm_only_in_load: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (arm_i && !clear_i) |-> (state_q == LOAD));

endmodule

// File: tb/tb_rv32i_store_checker.sv
// Drives two checkers (window 4 / timeout 40 and window 1 / timeout 10) with shared
// stimulus and compares both against a queue-style reference model every cycle.
module tb_rv32i_store_checker;
    localparam int DEPTH = 16;
    localparam int WIN [2] = '{4, 1};
    localparam int TMO [2] = '{40, 10};
    localparam logic [31:0] TOHOST = 32'h8000_1000;
    localparam int S_LOAD = 0, S_CHECK = 1, S_TOHOST = 2, S_DONE = 3;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i, exp_valid_i, arm_i, st_valid_i;
    logic [31:0] exp_addr_i, exp_data_i, st_addr_i, st_data_i;
    logic [3:0]  exp_strb_i, st_strb_i;

    logic        ready_w [2];
    logic        done_w [2];
    logic        pass_w [2];
    logic [2:0]  fc_w [2];
    logic [4:0]  matched_w [2];
    logic [3:0]  fidx_w [2];

    int total = 0;
    int bad   = 0;

    // Reference model state, one copy per checker; entries are kept in push order.
    logic [31:0] mAddr [2][DEPTH];
    logic [31:0] mData [2][DEPTH];
    logic [3:0]  mStrb [2][DEPTH];
    bit          mCons [2][DEPTH];
    int          mN [2], mHd [2], mSt [2], mTimer [2], mMatched [2], mFc [2], mFidx [2];
    bit          mDone [2], mPass [2];

    logic [31:0] ra [DEPTH];
    logic [31:0] rd [DEPTH];
    logic [3:0]  rs [DEPTH];
    int          ord [DEPTH];

    always #5 clk_i = ~clk_i;

    rv32i_store_checker #(.DEPTH(16), .ADDR_W(32), .DATA_W(32), .WINDOW(4),
                          .TIMEOUT_CYCLES(40), .TOHOST_ADDR(32'h8000_1000)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .exp_valid_i(exp_valid_i), .exp_ready_o(ready_w[0]),
        .exp_addr_i(exp_addr_i), .exp_data_i(exp_data_i), .exp_strb_i(exp_strb_i),
        .arm_i(arm_i), .st_valid_i(st_valid_i), .st_addr_i(st_addr_i),
        .st_data_i(st_data_i), .st_strb_i(st_strb_i),
        .done_o(done_w[0]), .pass_o(pass_w[0]), .fail_code_o(fc_w[0]),
        .matched_count_o(matched_w[0]), .fail_index_o(fidx_w[0]));

    rv32i_store_checker #(.DEPTH(16), .ADDR_W(32), .DATA_W(32), .WINDOW(1),
                          .TIMEOUT_CYCLES(10), .TOHOST_ADDR(32'h8000_1000)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .exp_valid_i(exp_valid_i), .exp_ready_o(ready_w[1]),
        .exp_addr_i(exp_addr_i), .exp_data_i(exp_data_i), .exp_strb_i(exp_strb_i),
        .arm_i(arm_i), .st_valid_i(st_valid_i), .st_addr_i(st_addr_i),
        .st_data_i(st_data_i), .st_strb_i(st_strb_i),
        .done_o(done_w[1]), .pass_o(pass_w[1]), .fail_code_o(fc_w[1]),
        .matched_count_o(matched_w[1]), .fail_index_o(fidx_w[1]));

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit entryHit(input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es,
                                    input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] ss);
        if (ea !== sa || es !== ss) return 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (es[b] && (ed[8*b +: 8] !== sd[8*b +: 8])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void mClear(int k);
        mN[k] = 0; mHd[k] = 0; mSt[k] = S_LOAD; mTimer[k] = 0; mMatched[k] = 0;
        mFc[k] = 0; mFidx[k] = 0; mDone[k] = 1'b0; mPass[k] = 1'b0;
        for (int i = 0; i < DEPTH; i++) mCons[k][i] = 1'b0;
    endfunction

    function automatic void mEnd(int k, bit passed, int code);
        mSt[k] = S_DONE; mDone[k] = 1'b1; mPass[k] = passed; mFc[k] = code;
    endfunction

    function automatic void mTick(int k);
        if (TMO[k] > 0) begin
            mTimer[k]++;
            if (mTimer[k] >= TMO[k]) mEnd(k, 1'b0, 4);
        end
    endfunction

    function automatic void mStep(int k);
        int found;
        int live;
        case (mSt[k])
            S_LOAD: begin
                if (exp_valid_i === 1'b1 && mN[k] < DEPTH) begin
                    mAddr[k][mN[k]] = exp_addr_i;
                    mData[k][mN[k]] = exp_data_i;
                    mStrb[k][mN[k]] = exp_strb_i;
                    mN[k]++;
                end
                if (arm_i === 1'b1) begin
                    mSt[k]    = (mN[k] > 0) ? S_CHECK : S_TOHOST;
                    mTimer[k] = 0;
                end
            end
            S_CHECK: begin
                if (st_valid_i === 1'b1) begin
                    mTimer[k] = 0;
                    found = -1;
                    live  = mN[k] - mHd[k];
                    for (int o = 0; o < WIN[k] && o < live; o++) begin
                        if (!mCons[k][mHd[k] + o] &&
                            entryHit(mAddr[k][mHd[k] + o], mData[k][mHd[k] + o], mStrb[k][mHd[k] + o],
                                     st_addr_i, st_data_i, st_strb_i)) begin
                            found = mHd[k] + o;
                            break;
                        end
                    end
                    if (found >= 0) begin
                        mCons[k][found] = 1'b1;
                        mMatched[k]++;
                        if (mMatched[k] == mN[k]) mEnd(k, 1'b1, 0);
                    end else begin
                        mFidx[k] = mHd[k] % DEPTH;
                        mEnd(k, 1'b0, 1);
                    end
                end else begin
                    mTick(k);
                end
                if (mHd[k] < mN[k] && mCons[k][mHd[k]]) mHd[k]++;
            end
            S_TOHOST: begin
                if (st_valid_i === 1'b1) begin
                    mTimer[k] = 0;
                    if (st_addr_i == TOHOST) mEnd(k, st_data_i == 32'd1, (st_data_i == 32'd1) ? 0 : 3);
                end else begin
                    mTick(k);
                end
            end
            default: ;
        endcase
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_ni || clear_i === 1'b1) mClear(k);
            else                             mStep(k);
        end
    end

    // Every cycle out of reset, both checkers must agree with the model.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput(k ? "cyc_ready1"   : "cyc_ready0",   32'(ready_w[k]),   32'(mSt[k] == S_LOAD && mN[k] < DEPTH));
                checkOutput(k ? "cyc_done1"    : "cyc_done0",    32'(done_w[k]),    32'(mDone[k]));
                checkOutput(k ? "cyc_pass1"    : "cyc_pass0",    32'(pass_w[k]),    32'(mPass[k]));
                checkOutput(k ? "cyc_fcode1"   : "cyc_fcode0",   32'(fc_w[k]),      32'(mFc[k]));
                checkOutput(k ? "cyc_matched1" : "cyc_matched0", 32'(matched_w[k]), 32'(mMatched[k]));
                checkOutput(k ? "cyc_findex1"  : "cyc_findex0",  32'(fidx_w[k]),    32'(mFidx[k]));
            end
        end
    end

    task automatic applyStimulus();
        @(negedge clk_i);
        clear_i     = 1'b0;
        exp_valid_i = 1'b0;
        arm_i       = 1'b0;
        st_valid_i  = 1'b0;
    endtask

    task automatic pushEntry(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_valid_i = 1'b1; exp_addr_i = a; exp_data_i = d; exp_strb_i = s;
        applyStimulus();
    endtask

    task automatic storeOp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        st_valid_i = 1'b1; st_addr_i = a; st_data_i = d; st_strb_i = s;
        applyStimulus();
    endtask

    task automatic armNow();
        arm_i = 1'b1;
        applyStimulus();
    endtask

    task automatic clearNow();
        clear_i = 1'b1;
        applyStimulus();
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus();
    endtask

    initial begin
        int cnt;
        int tmp;
        int j;
        logic [31:0] mask;
        logic [31:0] sd;
        logic [3:0]  ss;

        clear_i = 1'b0; exp_valid_i = 1'b0; arm_i = 1'b0; st_valid_i = 1'b0;
        exp_addr_i = '0; exp_data_i = '0; exp_strb_i = '0;
        st_addr_i = '0; st_data_i = '0; st_strb_i = '0;

        repeat (2) @(negedge clk_i);
        checkOutput("rst_done",    32'(done_w[0]),    32'd0);
        checkOutput("rst_pass",    32'(pass_w[0]),    32'd0);
        checkOutput("rst_fcode",   32'(fc_w[0]),      32'd0);
        checkOutput("rst_matched", 32'(matched_w[0]), 32'd0);
        checkOutput("rst_ready",   32'(ready_w[0]),   32'd1);
        rst_ni = 1'b1;

        // In-order pass on both checkers.
        pushEntry(32'h100, 32'hA, 4'hF);
        pushEntry(32'h104, 32'hB, 4'hF);
        pushEntry(32'h108, 32'hC, 4'hF);
        armNow();
        storeOp(32'h100, 32'hA, 4'hF);
        checkOutput("inorder_cnt1", 32'(matched_w[0]), 32'd1);
        storeOp(32'h104, 32'hB, 4'hF);
        checkOutput("inorder_cnt2", 32'(matched_w[0]), 32'd2);
        checkOutput("inorder_notdone", 32'(done_w[0]), 32'd0);
        storeOp(32'h108, 32'hC, 4'hF);
        checkOutput("inorder_cnt3",  32'(matched_w[0]), 32'd3);
        checkOutput("inorder_done",  32'(done_w[0]),    32'd1);
        checkOutput("inorder_pass",  32'(pass_w[0]),    32'd1);
        checkOutput("inorder_pass1", 32'(pass_w[1]),    32'd1);

        // Out-of-order: window 4 passes, window 1 fails on the first store.
        clearNow();
        pushEntry(32'h100, 32'hA, 4'hF);
        pushEntry(32'h104, 32'hB, 4'hF);
        pushEntry(32'h108, 32'hC, 4'hF);
        armNow();
        storeOp(32'h108, 32'hC, 4'hF);
        checkOutput("ooo_w1_fcode", 32'(fc_w[1]),   32'd1);
        checkOutput("ooo_w1_index", 32'(fidx_w[1]), 32'd0);
        checkOutput("ooo_w4_busy",  32'(done_w[0]), 32'd0);
        storeOp(32'h100, 32'hA, 4'hF);
        storeOp(32'h104, 32'hB, 4'hF);
        checkOutput("ooo_w4_pass",  32'(pass_w[0]), 32'd1);
        checkOutput("ooo_w4_fcode", 32'(fc_w[0]),   32'd0);

        // Byte-strobe masking.
        clearNow();
        pushEntry(32'h200, 32'h0000_00AA, 4'h1);
        armNow();
        storeOp(32'h200, 32'hFFFF_FFAA, 4'h1);
        checkOutput("strb_mask_pass", 32'(pass_w[0]), 32'd1);
        clearNow();
        pushEntry(32'h200, 32'h0000_00AA, 4'h1);
        armNow();
        storeOp(32'h200, 32'hFFFF_FFAA, 4'h3);
        checkOutput("strb_diff_fcode", 32'(fc_w[0]),   32'd1);
        checkOutput("strb_diff_pass",  32'(pass_w[0]), 32'd0);

        // tohost fallback.
        clearNow();
        armNow();
        storeOp(32'h1234, 32'd1, 4'hF);
        checkOutput("tohost_other_ignored", 32'(done_w[0]), 32'd0);
        storeOp(TOHOST, 32'd1, 4'hF);
        checkOutput("tohost_pass", 32'(pass_w[0]), 32'd1);
        clearNow();
        armNow();
        storeOp(TOHOST, 32'd3, 4'hF);
        checkOutput("tohost_fcode", 32'(fc_w[0]), 32'd3);

        // Watchdog on the 10-cycle checker.
        clearNow();
        armNow();
        idleCycles(9);
        checkOutput("wdog_early", 32'(done_w[1]), 32'd0);
        idleCycles(1);
        checkOutput("wdog_done",  32'(done_w[1]), 32'd1);
        checkOutput("wdog_fcode", 32'(fc_w[1]),   32'd4);
        checkOutput("wdog_long",  32'(done_w[0]), 32'd0);

        // Full buffer, reset mid-CHECK, push together with arm.
        clearNow();
        for (int i = 0; i < DEPTH; i++) pushEntry(32'h300 + 32'(4 * i), 32'(i), 4'hF);
        checkOutput("full_ready", 32'(ready_w[0]), 32'd0);
        pushEntry(32'h999, 32'h99, 4'hF);
        armNow();
        storeOp(32'h300, 32'd0, 4'hF);
        checkOutput("full_cnt1", 32'(matched_w[0]), 32'd1);
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_matched", 32'(matched_w[0]), 32'd0);
        checkOutput("midrst_done",    32'(done_w[0]),    32'd0);
        checkOutput("midrst_ready",   32'(ready_w[0]),   32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_valid_i = 1'b1; exp_addr_i = 32'h500; exp_data_i = 32'h5; exp_strb_i = 4'hF;
        arm_i = 1'b1;
        applyStimulus();
        storeOp(32'h500, 32'h5, 4'hF);
        checkOutput("pusharm_cnt",  32'(matched_w[0]), 32'd1);
        checkOutput("pusharm_pass", 32'(pass_w[0]),    32'd1);

        // Randomized runs, checked by the per-cycle compare.
        for (int it = 0; it < 40; it++) begin
            clearNow();
            cnt = $urandom_range(0, 17);
            for (int i = 0; i < cnt; i++) begin
                if (i < DEPTH) begin
                    ra[i] = 32'h400 + 32'(4 * $urandom_range(0, 7));
                    rd[i] = $urandom;
                    rs[i] = 4'($urandom_range(1, 15));
                    pushEntry(ra[i], rd[i], rs[i]);
                end else begin
                    pushEntry(32'hDEAD, 32'hBEEF, 4'hF);
                end
                if ($urandom_range(0, 3) == 0) idleCycles(1);
            end
            armNow();
            if (cnt == 0) begin
                repeat (3) begin
                    idleCycles($urandom_range(0, 3));
                    storeOp(($urandom_range(0, 1) == 0) ? TOHOST : 32'h400, 32'($urandom_range(0, 2)), 4'hF);
                end
            end else begin
                if (cnt > DEPTH) cnt = DEPTH;
                for (int i = 0; i < cnt; i++) ord[i] = i;
                for (int i = 0; i < cnt - 1; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        tmp = ord[i]; ord[i] = ord[i + 1]; ord[i + 1] = tmp;
                    end
                end
                for (int i = 0; i < cnt; i++) begin
                    j    = ord[i];
                    mask = {{8{rs[j][3]}}, {8{rs[j][2]}}, {8{rs[j][1]}}, {8{rs[j][0]}}};
                    sd   = (rd[j] & mask) | ($urandom & ~mask);
                    ss   = rs[j];
                    if ($urandom_range(0, 15) == 0) sd = sd ^ (mask & 32'h0101_0101);
                    if ($urandom_range(0, 15) == 0) ss = 4'($urandom_range(1, 15));
                    if ($urandom_range(0, 19) == 0) begin
                        st_valid_i = 1'bx; st_addr_i = ra[j]; st_data_i = sd; st_strb_i = ss;
                        applyStimulus();
                    end
                    idleCycles($urandom_range(0, 2));
                    storeOp(ra[j], sd, ss);
                end
            end
            idleCycles(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rv32i_store_checker.md
Name: rv32i_store_checker

Overview:
- Synthesizable, parametrised successor to the bench store scoreboard; usable in simulation and in FPGA self-checking builds.
- Holds an expectation buffer loaded at runtime through a valid/ready push port, not from a file.
- Checks the core's store stream with byte-strobe masking and a bounded out-of-order match window.
- Falls back to the tohost pass/fail convention when no expectations are loaded, and adds a watchdog timeout.

Parameters:
- DEPTH, 16: expectation buffer entries; power of two, at least 2.
- ADDR_W, 32: store address width.
- DATA_W, 32: store data width; multiple of 8.
- WINDOW, 4: number of entries from head eligible for matching; 1 gives strict in-order checking; must be between 1 and DEPTH.
- TIMEOUT_CYCLES, 100000: idle-cycle watchdog limit; 0 disables it.
- TOHOST_ADDR, 32'h8000_1000: tohost address used in fallback mode.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush back to LOAD
- exp_valid_i  in  1  expectation push valid
- exp_ready_o  out  1  push accepted when high (LOAD state and not full)
- exp_addr_i  in  ADDR_W  expected address
- exp_data_i  in  DATA_W  expected data
- exp_strb_i  in  DATA_W/8  expected byte strobes
- arm_i  in  1  end of loading; start checking
- st_valid_i  in  1  store observed
- st_addr_i  in  ADDR_W  store address
- st_data_i  in  DATA_W  store data
- st_strb_i  in  DATA_W/8  store byte strobes
- done_o  out  1  sticky completion
- pass_o  out  1  sticky pass
- fail_code_o  out  3  0 none, 1 mismatch, 2 unexpected store, 3 tohost fail, 4 timeout
- matched_count_o  out  $clog2(DEPTH+1)  stores matched so far
- fail_index_o  out  $clog2(DEPTH)  buffer slot at head when a mismatch occurred

Behaviour:
- Reset and clear: rst_ni low or clear_i high -> state LOAD, buffer empty, all consumed bits cleared; done_o=0, pass_o=0, fail_code_o=0, matched_count_o=0, fail_index_o=0, timer=0.
- clear_i has priority over every other input.
- States:
  - LOAD: push handshake fires when exp_valid_i and exp_ready_o are both high. Stores are ignored. On arm_i: go to CHECK if count>0 (counting a push in the same cycle), otherwise go to TOHOST.
  - CHECK: exp_ready_o=0.
    - Candidates are the live, unconsumed entries at offsets 0..min(WINDOW,occupancy)-1 from head.
    - An entry matches when addresses are equal, strobes are equal, and data bytes enabled by exp_strb are equal; bytes not enabled are don't-care. Compare with 4-state equality (X/Z mismatches).
    - Lowest-offset match wins and its consumed bit is set.
    - No match with remaining>0 -> fail code 1. A store when remaining==0 cannot occur (DONE is entered first).
    - Head pops one consumed entry per cycle; occupancy counts unpopped entries; remaining counts unconsumed entries.
    - remaining reaching 0 after a match -> DONE with pass_o=1 on the same edge.
  - TOHOST: a store to TOHOST_ADDR -> DONE; pass_o=1 when data==1, otherwise fail code 3. All other stores are ignored.
  - DONE: sticky; all inputs are ignored except clear_i.
- Latency: a store sampled at edge k is reflected in done_o, pass_o, fail_code_o and matched_count_o after edge k (registered, one cycle).
- On any fail: done_o=1, pass_o=0, and the first fail code is frozen. In CHECK, fail_index_o = head slot on a mismatch.
- Watchdog (CHECK and TOHOST only): the timer resets on arm and on every st_valid_i. Reaching TIMEOUT_CYCLES -> DONE with fail code 4. A store arriving in the same cycle takes precedence over the timeout.
- Buffer pointers wrap modulo DEPTH. Full is signalled when occupancy==DEPTH, which drives exp_ready_o low.
- Stores carrying X on st_valid_i are treated as not valid.
- Simulation-only assertion: arm_i must not be raised outside LOAD.

Test Plan:
- Push 3 entries (0x100/0xA, 0x104/0xB, 0x108/0xC, strb 0xF), arm, then store them in order -> matched_count_o 1,2,3; done_o=pass_o=1 on the edge after the third store.
- WINDOW=4: same 3 entries stored in order 0x108, 0x100, 0x104 -> pass. With WINDOW=1, the same order -> fail_code_o=1 on the first store, fail_index_o=0.
- Entry 0x200/0x0000_00AA with strb 0x1; store 0x200/0xFFFF_FFAA with strb 0x1 -> match. Same store with strb 0x3 -> fail_code_o=1.
- Arm with an empty buffer, then store 0x8000_1000/1 -> pass. Repeat after clear_i with data 3 -> fail_code_o=3.
- TIMEOUT_CYCLES=10: arm with no stores -> done_o=1 and fail_code_o=4 exactly 10 cycles after arm.
- Push 16 entries -> exp_ready_o low on the 17th push. Assert rst_ni mid-CHECK -> all outputs 0 and state LOAD. Push and arm in the same cycle -> that entry is counted.
